// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: parity encodings, FSM state
// type, the divisor floor, and the parity-bit helper.
package uart_pkg;

  // parity_mode encodings
  localparam logic [1:0] PAR_NONE  = 2'd0;
  localparam logic [1:0] PAR_EVEN  = 2'd1;
  localparam logic [1:0] PAR_ODD   = 2'd2;
  localparam logic [1:0] PAR_SPACE = 2'd3;

  // Smallest divisor the bit timer honours; smaller requests are raised to it.
  localparam int unsigned MIN_DIV = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Parity bit for a frame, given the mode and the XOR of its data bits.
  function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
    logic bit_val;
    case (mode)
      PAR_EVEN:  bit_val = data_xor;
      PAR_ODD:   bit_val = ~data_xor;
      PAR_SPACE: bit_val = 1'b0;
      default:   bit_val = 1'b0;
    endcase
    return bit_val;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO feeding the UART shifter. Storage is a plain array
// with a registered read of the head word, so rd_valid rises one cycle after
// a word lands in an empty FIFO. level counts every stored word.
module uart_tx_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [LW-1:0]    count_reg;
  logic             push;
  logic             take;

  assign full        = (count_reg == LW'(DEPTH));
  assign empty       = (count_reg == '0);
  assign level       = count_reg;
  assign push        = wr_en && !full;
  assign take        = pop && rd_valid;
  assign rd_ptr_next = take ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

  // Storage write; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Registered read of the word that will be the head after this edge.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_ptr_next];
  end

  // Pointers, occupancy, and head-valid tracking. The head is only valid
  // when it was written before this edge (the read sees pre-write contents).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      rd_valid   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_reg + LW'(push) - LW'(take);
      rd_valid   <= ((count_reg - LW'(take)) != '0);
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// Parametrised UART transmitter: valid/ready input, word buffer, runtime
// divisor / parity / stop-bit / bit-order selection, registered TX line.
// Build option UART_TX_FIFO_EN: defined -> FIFO_DEPTH-entry FIFO buffer;
// undefined -> single holding register in front of the shifter.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 16,
  parameter  int DIV_W      = 18,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              CLK_50M,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic              msb_first,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              busy,
  output logic              tx_done,
  output logic              TX
);

  localparam logic [3:0] IDX_LAST = 4'(DATA_W - 1);

  // Buffer-side signals
  logic [DATA_W-1:0] head_data;
  logic              head_valid;
  logic              queue_empty;
  logic              pop;

  // FSM and datapath
  tx_state_t         state_reg, state_next;
  logic [DIV_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [DIV_W-1:0]  div_reg;
  logic [DIV_W-1:0]  div_eff;
  logic              bit_last;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [3:0]        bit_idx_reg;
  logic              stop_idx_reg;
  logic [1:0]        par_reg;
  logic              stop2_reg;
  logic              msb_reg;
  logic              par_bit_reg;
  logic              tx_reg, tx_next;

`ifdef UART_TX_FIFO_EN
  logic queue_full;

  uart_tx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK_50M),
    .rst     (rst),
    .wr_en   (s_valid),
    .wr_data (s_data),
    .pop     (pop),
    .rd_data (head_data),
    .rd_valid(head_valid),
    .full    (queue_full),
    .empty   (queue_empty),
    .level   (fifo_level)
  );

  assign s_ready = !queue_full;
`else
  logic [DATA_W-1:0] hold_data_reg;
  logic              hold_full_reg;
  logic              hold_valid_reg;
  logic              hold_push;

  assign hold_push   = s_valid && !hold_full_reg;
  assign head_data   = hold_data_reg;
  assign head_valid  = hold_valid_reg;
  assign queue_empty = !hold_full_reg;
  assign s_ready     = !hold_full_reg;
  assign fifo_level  = LVL_W'(hold_full_reg);

  // Holding register data; loaded whenever a word is accepted.
  always_ff @(posedge CLK_50M) begin
    if (hold_push) begin
      hold_data_reg <= s_data;
    end
  end

  // Occupancy; valid lags full by a cycle to match the FIFO's read latency.
  always_ff @(posedge CLK_50M or posedge rst) begin
    if (rst) begin
      hold_full_reg  <= 1'b0;
      hold_valid_reg <= 1'b0;
    end else begin
      if (hold_push) begin
        hold_full_reg <= 1'b1;
      end else if (pop) begin
        hold_full_reg <= 1'b0;
      end
      hold_valid_reg <= hold_full_reg && !pop;
    end
  end
`endif

  assign div_eff  = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
  assign bit_last = (bit_cnt_reg == div_reg - DIV_W'(1));
  assign busy     = (state_reg != IDLE) || !queue_empty;
  assign TX       = tx_reg;

  // Next-state, pop request and end-of-frame pulse.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    tx_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (head_valid) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_last) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_last && (bit_idx_reg == IDX_LAST)) begin
          state_next = (par_reg == PAR_NONE) ? STOP : PARITY;
        end
      end
      PARITY: begin
        if (bit_last) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_last && (stop_idx_reg || !stop2_reg)) begin
          tx_done = 1'b1;
          if (head_valid) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shifter, bit counter and the line value for the coming cycle.
  always_comb begin
    shift_next = shift_reg;
    if (pop) begin
      shift_next = head_data;
    end else if ((state_reg == DATA) && bit_last) begin
      shift_next = msb_reg ? (shift_reg << 1) : (shift_reg >> 1);
    end

    bit_cnt_next = bit_cnt_reg + DIV_W'(1);
    if ((state_next != state_reg) || bit_last || (state_reg == IDLE)) begin
      bit_cnt_next = '0;
    end

    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = msb_reg ? shift_next[DATA_W-1] : shift_next[0];
      PARITY:  tx_next = par_bit_reg;
      default: tx_next = 1'b1;
    endcase
  end

  // State, counter, shifter and line registers.
  always_ff @(posedge CLK_50M or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
    end
  end

  // Frame configuration, captured only when a word is popped.
  always_ff @(posedge CLK_50M or posedge rst) begin
    if (rst) begin
      div_reg     <= DIV_W'(MIN_DIV);
      par_reg     <= PAR_NONE;
      stop2_reg   <= 1'b0;
      msb_reg     <= 1'b0;
      par_bit_reg <= 1'b0;
    end else if (pop) begin
      div_reg     <= div_eff;
      par_reg     <= parity_mode;
      stop2_reg   <= stop2;
      msb_reg     <= msb_first;
      par_bit_reg <= parity_bit(parity_mode, ^head_data);
    end
  end

  // Position counters within the data field and the stop field.
  always_ff @(posedge CLK_50M or posedge rst) begin
    if (rst) begin
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
    end else begin
      if (state_reg != DATA) begin
        bit_idx_reg <= '0;
      end else if (bit_last) begin
        bit_idx_reg <= bit_idx_reg + 4'd1;
      end
      if (state_reg != STOP) begin
        stop_idx_reg <= 1'b0;
      end else if (bit_last) begin
        stop_idx_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: stimulus pushes expected frames into a queue, a
// monitor decodes the TX line cycle by cycle and compares against the queue.
module tb_uart_tx_core;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DIVW  = 18;
  localparam int LVLW  = $clog2(DEPTH + 1);
`ifdef UART_TX_FIFO_EN
  localparam int FIRST_BLOCK = DEPTH + 1;
`else
  localparam int FIRST_BLOCK = 1;
`endif

  logic            CLK_50M = 1'b0;
  logic            rst = 1'b1;
  logic [DIVW-1:0] baud_div = DIVW'(4);
  logic [1:0]      parity_mode = 2'd0;
  logic            stop2 = 1'b0;
  logic            msb_first = 1'b0;
  logic [DW-1:0]   s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [LVLW-1:0] fifo_level;
  logic            busy;
  logic            tx_done;
  logic            TX;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  uart_tx_core #(
    .DATA_W    (DW),
    .FIFO_DEPTH(DEPTH),
    .DIV_W     (DIVW)
  ) dut (
    .CLK_50M    (CLK_50M),
    .rst        (rst),
    .baud_div   (baud_div),
    .parity_mode(parity_mode),
    .stop2      (stop2),
    .msb_first  (msb_first),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .fifo_level (fifo_level),
    .busy       (busy),
    .tx_done    (tx_done),
    .TX         (TX)
  );

  always #10 CLK_50M = ~CLK_50M;
  always @(posedge CLK_50M) cyc <= cyc + 1;

  typedef struct {
    logic [15:0]   bits;   // line level of each bit slot, slot 0 first
    int            nbits;
    int            div;
    bit            chk_gap;
    logic [DW-1:0] word;
  } frame_t;

  frame_t exp_q[$];

  // Reference frame from the protocol rules.
  function automatic frame_t make_frame(input logic [DW-1:0] w, input int div, input int pmode,
                                        input bit st2, input bit msb, input bit gap);
    frame_t f;
    int n;
    int ones;
    f.bits = '1;
    f.div = (div < 4) ? 4 : div;
    f.chk_gap = gap;
    f.word = w;
    f.bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) f.bits[1 + i] = msb ? w[DW - 1 - i] : w[i];
    n = 1 + DW;
    ones = $countones(w);
    if (pmode != 0) begin
      f.bits[n] = (pmode == 1) ? logic'(ones % 2) : (pmode == 2) ? logic'(1 - ones % 2) : 1'b0;
      n++;
    end
    n += st2 ? 2 : 1;
    f.nbits = n;
    return f;
  endfunction

  function automatic frame_t fixed_frame(input logic [DW-1:0] w, input logic [15:0] seq, input int n);
    frame_t f;
    f.bits = seq;
    f.nbits = n;
    f.div = 4;
    f.chk_gap = 1'b0;
    f.word = w;
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  frame_t cur;
  bit   in_frame = 0;
  bit   rogue = 0;
  bit   mon_off = 0;
  bit   ferr = 0;
  int   pos = 0;
  int   idle_cnt = 0;
  int   err_pos = 0;
  logic err_tx, err_done, err_etx, err_edone;

  initial begin
    forever begin
      @(negedge CLK_50M);
      if (rst || mon_off) begin
        in_frame = 0;
        rogue = 0;
        idle_cnt = 0;
      end else begin
        if (!in_frame) begin
          if (rogue) begin
            if (TX === 1'b1) rogue = 0;
          end else if (TX !== 1'b1) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame: TX=%b with no word queued", TX);
              rogue = 1;
            end else begin
              cur = exp_q.pop_front();
              in_frame = 1;
              pos = 0;
              ferr = 0;
              if (cur.chk_gap) begin
                checks++;
                if (idle_cnt != 0) begin
                  errors++;
                  $display("FAIL frame_gap: got %0d idle cycles before word %h, expected 0",
                           idle_cnt, cur.word);
                end
              end
            end
          end else begin
            if (tx_done !== 1'b0) begin
              checks++;
              errors++;
              $display("FAIL stray_tx_done: got %b while idle, expected 0", tx_done);
            end
            idle_cnt++;
          end
        end
        if (in_frame) begin
          if (!ferr && ((TX !== cur.bits[pos / cur.div]) ||
                        (tx_done !== logic'(pos == cur.nbits * cur.div - 1)))) begin
            ferr = 1;
            err_pos = pos;
            err_tx = TX;
            err_done = tx_done;
            err_etx = cur.bits[pos / cur.div];
            err_edone = logic'(pos == cur.nbits * cur.div - 1);
          end
          pos++;
          if (pos == cur.nbits * cur.div) begin
            checks++;
            if (ferr) begin
              errors++;
              $display("FAIL frame word=%h: cycle %0d got TX=%b tx_done=%b expected TX=%b tx_done=%b",
                       cur.word, err_pos, err_tx, err_done, err_etx, err_edone);
            end else begin
              $display("frame word=%h bits=%0d div=%0d ok", cur.word, cur.nbits, cur.div);
            end
            in_frame = 0;
            idle_cnt = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [DW-1:0] w, input frame_t f, input bit do_push);
    int waited = 0;
    @(negedge CLK_50M);
    s_data = w;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && waited < 2000) begin
      @(negedge CLK_50M);
      waited++;
    end
    if (s_ready !== 1'b1) begin
      chk("send_timeout", 32'(s_ready), 32'd1);
      s_valid = 1'b0;
    end else begin
      if (do_push) exp_q.push_back(f);
      $display("send word=%h", w);
      @(posedge CLK_50M);
      #1 s_valid = 1'b0;
    end
  endtask

  task automatic send_model(input logic [DW-1:0] w, input bit gap);
    send(w, make_frame(w, int'(baud_div), int'(parity_mode), stop2, msb_first, gap), 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK_50M);
    while ((busy !== 1'b0 || exp_q.size() != 0 || in_frame) && n < 5000) begin
      @(negedge CLK_50M);
      n++;
    end
    if (n >= 5000) begin
      chk("idle_timeout", 32'(busy), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic wait_tx_low(output int c0);
    int n = 0;
    @(negedge CLK_50M);
    while (TX !== 1'b0 && n < 100) begin
      @(negedge CLK_50M);
      n++;
    end
    if (TX !== 1'b0) chk("start_timeout", 32'(TX), 32'd0);
    c0 = cyc;
  endtask

  task automatic do_reset();
    @(negedge CLK_50M);
    #2 rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge CLK_50M);
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c0;
    int cnt;
    int idx;
    int first_block;
    int nw;
    logic [DW-1:0] burst_w [6];
    logic [DW-1:0] w;
    frame_t dummy;

    dummy = fixed_frame('0, '1, 1);

    // Reset values
    repeat (3) @(negedge CLK_50M);
    chk("reset_TX", 32'(TX), 32'd1);
    chk("reset_s_ready", 32'(s_ready), 32'd1);
    chk("reset_fifo_level", 32'(fifo_level), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_tx_done", 32'(tx_done), 32'd0);
    rst = 1'b0;

    // Basic frame: div 4, even parity, one stop, LSB first, 0xA5
    baud_div = DIVW'(4); parity_mode = 2'd1; stop2 = 1'b0; msb_first = 1'b0;
    send(8'hA5, fixed_frame(8'hA5, 16'b101_0100_1010, 11), 1'b1);
    @(posedge CLK_50M); #1;
    chk("lat_n1_level", 32'(fifo_level), 32'd1);
    chk("lat_n1_TX", 32'(TX), 32'd1);
    @(posedge CLK_50M); #1;
    chk("lat_n2_TX", 32'(TX), 32'd0);
    chk("lat_n2_level", 32'(fifo_level), 32'd0);
    chk("lat_n2_busy", 32'(busy), 32'd1);
    wait_idle();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_TX", 32'(TX), 32'd1);

    // Odd parity, two stops, MSB first
    parity_mode = 2'd2; stop2 = 1'b1; msb_first = 1'b1;
    send(8'hA5, fixed_frame(8'hA5, 16'b1111_0100_1010, 12), 1'b1);
    wait_idle();

    // Divisor clamp: requested 1, each bit lasts 4 cycles
    baud_div = DIVW'(1); parity_mode = 2'd0; stop2 = 1'b0; msb_first = 1'b0;
    send(8'h3C, make_frame(8'h3C, 4, 0, 1'b0, 1'b0, 1'b0), 1'b1);
    wait_idle();

    // Real rate: start bit of 5208 cycles, then abandon the frame
    mon_off = 1'b1;
    baud_div = DIVW'(5208);
    send(8'h01, dummy, 1'b0);
    wait_tx_low(c0);
    cnt = 0;
    while (TX === 1'b0 && cnt < 6000) begin
      cnt++;
      @(negedge CLK_50M);
    end
    chk("start_bit_5208", 32'(cnt), 32'd5208);
    do_reset();
    mon_off = 1'b0;

    // Back-to-back burst with s_valid held high
    baud_div = DIVW'(4); parity_mode = 2'd1; stop2 = 1'b0; msb_first = 1'b0;
    for (int i = 0; i < 6; i++) burst_w[i] = DW'($urandom_range(0, 255));
    idx = 0;
    first_block = -1;
    cnt = 0;
    while (idx < 6 && cnt < 5000) begin
      @(negedge CLK_50M);
      cnt++;
      s_valid = 1'b1;
      s_data = burst_w[idx];
      if (s_ready === 1'b1) begin
        exp_q.push_back(make_frame(burst_w[idx], 4, 1, 1'b0, 1'b0, idx > 0));
        $display("send word=%h (burst)", burst_w[idx]);
        idx++;
      end else if (first_block < 0) begin
        first_block = idx;
      end
    end
    @(posedge CLK_50M);
    #1 s_valid = 1'b0;
    chk("burst_accepted_before_full", 32'(first_block), 32'(FIRST_BLOCK));
    wait_idle();

    // Reset during data bit 3 with a second word buffered
    parity_mode = 2'd0;
    send_model(8'h00, 1'b0);
    wait_tx_low(c0);
    send_model(8'h3C, 1'b0);
    while (cyc - c0 < 17) @(negedge CLK_50M);
    chk("pre_reset_TX", 32'(TX), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_TX_async", 32'(TX), 32'd1);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    exp_q.delete();
    repeat (2) @(negedge CLK_50M);
    rst = 1'b0;
    send_model(8'h5A, 1'b0);
    wait_idle();

    // Parity change during DATA affects only the next frame
    parity_mode = 2'd1;
    send_model(8'hB7, 1'b0);
    wait_tx_low(c0);
    repeat (8) @(negedge CLK_50M);
    parity_mode = 2'd2;
    send_model(8'hB7, 1'b0);
    wait_idle();

    // Randomised configurations and words
    for (int b = 0; b < 8; b++) begin
      baud_div = DIVW'($urandom_range(1, 7));
      parity_mode = 2'($urandom_range(0, 3));
      stop2 = 1'($urandom_range(0, 1));
      msb_first = 1'($urandom_range(0, 1));
      nw = $urandom_range(1, 4);
      for (int k = 0; k < nw; k++) begin
        w = DW'($urandom_range(0, 255));
        send_model(w, 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge CLK_50M);
      end
      wait_idle();
    end

    repeat (5) @(negedge CLK_50M);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Parametrised UART transmitter that replaces the fixed 8-bit, fixed-parity transmitter in the serial-out path. It accepts words over a valid/ready stream, buffers them in a small FIFO, and serialises each word using a runtime baud divisor, runtime parity/stop/bit-order selection and a compile-time data width. The per-bit counter restarts at every frame start, so TX latency is deterministic rather than aligned to a free-running baud tick. It sits between the BRAM readout logic and the board TX pin.

## Interface
- DATA_W, 8, data bits per frame, legal range 5..9.
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 2.
- DIV_W, 18, width of the baud divisor (covers 300 bd at 50 MHz).
- CLK_50M  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- baud_div  in  DIV_W  clock cycles per bit; values below 4 are treated as 4.
- parity_mode  in  2  0 none, 1 even, 2 odd, 3 space (constant 0).
- stop2  in  1  1 selects two stop bits, 0 selects one.
- msb_first  in  1  1 sends data MSB first, 0 sends LSB first.
- s_data  in  DATA_W  word to send.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  the block can accept a word (FIFO not full).
- fifo_level  out  $clog2(FIFO_DEPTH+1)  number of words stored, excluding the word being shifted.
- busy  out  1  a frame is in progress, or the FIFO is not empty.
- tx_done  out  1  one-cycle pulse on the final cycle of the last stop bit.
- TX  out  1  serial line, registered, idles high.

## Operation
- Handshake:
  - A word is written on any rising edge where s_valid and s_ready are both high.
  - s_ready equals "FIFO not full". It does not depend on s_valid.
  - Writing and popping in the same cycle is legal; fifo_level stays unchanged.
- FSM states and transitions:
  - IDLE -> START when the FIFO is not empty. On that edge the block pops one word into the shift register and latches baud_div, parity_mode, stop2 and msb_first.
  - START -> DATA.
  - DATA -> PARITY after DATA_W bits, or DATA -> STOP if parity_mode is 0.
  - PARITY -> STOP.
  - STOP -> START if the FIFO is not empty (back-to-back frames, no idle gap), otherwise STOP -> IDLE.
- Bit values:
  - TX is 0 in START and 1 in STOP and IDLE.
  - In DATA, TX carries the shift register bit, MSB or LSB first as latched.
  - Even parity bit is the XOR of the data bits. Odd parity is its inverse. Space parity is 0.
- Bit timing:
  - Every bit lasts exactly the latched divisor's cycle count.
  - A bit counter of DIV_W bits runs from 0 to div-1 and reloads at every state change.
  - STOP lasts one bit period, or two if stop2 was latched.
- Config changes take effect on a frame only if they occur before its START. Changing inputs mid-frame does not affect that frame.
- Reset, including mid-frame: TX goes to 1 immediately (asynchronously), the FIFO empties, the FSM returns to IDLE, and the partial frame is abandoned.
- Reset values: TX=1, s_ready=1, fifo_level=0, busy=0, tx_done=0.

## Timing
- Accept at edge N into an empty FIFO while IDLE:
  - edge N+1: fifo_level=1.
  - edge N+2: pop; TX falls.
- Frame length in cycles is div × (1 + DATA_W + (parity?1:0) + (stop2?2:1)).
- tx_done is high during the final cycle of STOP. On the next edge either START begins (TX falls) or IDLE is entered.
- Storage: the block holds FIFO_DEPTH words in the FIFO plus one word in the shifter.

## Configuration
- Macro: UART_TX_FIFO_EN.
- Defined: the FIFO is FIFO_DEPTH entries deep, as described above.
- Undefined:
  - The FIFO is replaced by a single holding register and FIFO_DEPTH is ignored.
  - s_ready is high whenever the holding register is empty; fifo_level is 0 or 1.
  - All other timing is unchanged.

## Structure
- Package uart_pkg:
  - parity_mode encoding constants (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_SPACE).
  - FSM state typedef (IDLE, START, DATA, PARITY, STOP).
  - minimum-divisor constant (4).
- Sub-module uart_tx_fifo:
  - synchronous FIFO with a write/pop interface, full/empty flags and level output.
  - used only when UART_TX_FIFO_EN is defined.
- The FSM, bit counter and shifter stay in uart_tx_core.

## Test plan
- **Basic frame:** baud_div=4, parity even, stop2=0, LSB first, send 0xA5 -> TX sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles, 44 cycles total; tx_done pulses once.
- **Odd parity, two stops, MSB first:** baud_div=4, send 0xA5 -> TX 0,1,0,1,0,0,1,0,1,1,1,1; 48 cycles.
- **Divisor clamp and real rate:** baud_div=1 -> each bit 4 cycles; baud_div=5208 -> start bit exactly 5208 cycles.
- **Back-to-back and full:** FIFO_DEPTH=4, burst of 6 words with s_valid held high -> s_ready drops after 5 accepted words; all frames are contiguous with no idle cycles; order is preserved.
- **Reset mid-frame:** assert rst during data bit 3 -> TX=1 the same cycle, fifo_level=0, busy=0; after release a new word transmits normally.
- **Config change mid-frame:** toggle parity_mode from 1 to 2 during DATA -> the current frame keeps even parity and the next frame uses odd.
